nios2_ram_width_adapter: RTL and testbench

- Bridges the Nios II 32-bit Avalon-MM data path to the 16-bit single-port on-chip RAM (51200 x 16, byte-enabled, 1-cycle read latency, unregistered output).
- Splits each 32-bit read or write into sequential low/high halfword RAM accesses and reassembles read data.
- Drops out-of-range accesses.
- Sits directly upstream of the RAM; its master-side outputs drive the RAM's address/byteenable/chipselect/write/writedata/clken pins.

---
 rtl/nios2_ram_width_adapter_if.sv | 26 ++
 rtl/nios2_ram_width_adapter.sv | 166 ++++++++++++++++
 tb/tb_nios2_ram_width_adapter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_ram_width_adapter_if.sv
// Generic Avalon-MM bus bundle shared by the 32-bit CPU side and the 16-bit RAM side.
interface nios2_ram_width_adapter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                chipselect;
    logic                clken;

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

    modport master (
        output address, byteenable, chipselect, write, writedata, clken,
        input  readdata
    );
endinterface

// File: rtl/nios2_ram_width_adapter.sv
// Splits 32-bit Avalon-MM accesses into two 16-bit RAM halfword cycles and
// reassembles read data; accesses beyond the RAM are accepted and dropped.
module nios2_ram_width_adapter #(
    parameter int RAM_DEPTH = 51200
) (
    input  logic                          clk,
    input  logic                          reset,
    nios2_ram_width_adapter_if.slave      s,
    nios2_ram_width_adapter_if.master     m
);
    typedef enum logic [1:0] {IDLE, LO, HI, RLAST} state_t;

    localparam logic [15:0] WORDS = 16'(RAM_DEPTH / 2);

    state_t      state_q, state_d;
    logic [14:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wd_q, wd_d;
    logic        isRead_q, isRead_d;
    logic [15:0] loData_q, loData_d;
    logic [31:0] rdData_q, rdData_d;
    logic        rdValid_q, rdValid_d;
    logic [15:0] mAddr_q, mAddr_d;
    logic [1:0]  mBe_q, mBe_d;
    logic [15:0] mWd_q, mWd_d;
    logic        mCs_q, mCs_d;
    logic        mWr_q, mWr_d;

    logic [14:0] cmdAddr;
    logic [3:0]  cmdBe;
    logic [31:0] cmdWd;
    logic        inRange;

    // In IDLE the RAM-side registers are loaded straight from the request so
    // the first halfword cycle starts the cycle after acceptance.
    always_comb begin
        cmdAddr   = (state_q == IDLE) ? s.address    : addr_q;
        cmdBe     = (state_q == IDLE) ? s.byteenable : be_q;
        cmdWd     = (state_q == IDLE) ? s.writedata  : wd_q;
        inRange   = ({1'b0, s.address} < WORDS);

        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wd_d      = wd_q;
        isRead_d  = isRead_q;
        loData_d  = loData_q;
        rdData_d  = rdData_q;
        rdValid_d = 1'b0;
        mAddr_d   = mAddr_q;
        mBe_d     = mBe_q;
        mWd_d     = mWd_q;
        mCs_d     = 1'b0;
        mWr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (s.read || s.write) begin
                    addr_d   = s.address;
                    be_d     = s.byteenable;
                    wd_d     = s.writedata;
                    isRead_d = !s.write;
                    if (!inRange) begin
                        if (!s.write) begin
                            rdData_d  = '0;
                            rdValid_d = 1'b1;
                        end
                    end else if (!s.write) begin
                        state_d = LO;
                        mAddr_d = {cmdAddr, 1'b0};
                        mBe_d   = 2'b11;
                        mCs_d   = 1'b1;
                    end else if (cmdBe[1:0] != 2'b00) begin
                        state_d = LO;
                        mAddr_d = {cmdAddr, 1'b0};
                        mBe_d   = cmdBe[1:0];
                        mWd_d   = cmdWd[15:0];
                        mCs_d   = 1'b1;
                        mWr_d   = 1'b1;
                    end else if (cmdBe[3:2] != 2'b00) begin
                        state_d = HI;
                        mAddr_d = {cmdAddr, 1'b1};
                        mBe_d   = cmdBe[3:2];
                        mWd_d   = cmdWd[31:16];
                        mCs_d   = 1'b1;
                        mWr_d   = 1'b1;
                    end
                end
            end
            LO: begin
                if (isRead_q) begin
                    state_d = HI;
                    mAddr_d = {cmdAddr, 1'b1};
                    mBe_d   = 2'b11;
                    mCs_d   = 1'b1;
                end else if (cmdBe[3:2] != 2'b00) begin
                    state_d = HI;
                    mAddr_d = {cmdAddr, 1'b1};
                    mBe_d   = cmdBe[3:2];
                    mWd_d   = cmdWd[31:16];
                    mCs_d   = 1'b1;
                    mWr_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HI: begin
                // RAM output now carries the low halfword addressed during LO.
                if (isRead_q) begin
                    loData_d = m.readdata;
                    state_d  = RLAST;
                end else begin
                    state_d  = IDLE;
                end
            end
            RLAST: begin
                rdData_d  = {m.readdata, loData_q};
                rdValid_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wd_q      <= '0;
            isRead_q  <= 1'b0;
            loData_q  <= '0;
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
            mAddr_q   <= '0;
            mBe_q     <= '0;
            mWd_q     <= '0;
            mCs_q     <= 1'b0;
            mWr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wd_q      <= wd_d;
            isRead_q  <= isRead_d;
            loData_q  <= loData_d;
            rdData_q  <= rdData_d;
            rdValid_q <= rdValid_d;
            mAddr_q   <= mAddr_d;
            mBe_q     <= mBe_d;
            mWd_q     <= mWd_d;
            mCs_q     <= mCs_d;
            mWr_q     <= mWr_d;
        end
    end

    assign s.waitrequest   = reset | (state_q != IDLE);
    assign s.readdata      = rdData_q;
    assign s.readdatavalid = rdValid_q;
    assign m.address       = mAddr_q;
    assign m.byteenable    = mBe_q;
    assign m.writedata     = mWd_q;
    assign m.chipselect    = mCs_q;
    assign m.write         = mWr_q;
    assign m.clken         = ~reset;
endmodule

// File: tb/tb_nios2_ram_width_adapter.sv
// Bench for the 32-to-16 RAM width adapter: vector table, cycle-exact corner
// sequences and random traffic checked against a word-level memory model.
module tb_nios2_ram_width_adapter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nios2_ram_width_adapter_if #(.ADDR_W(15), .DATA_W(32)) sBus ();
    nios2_ram_width_adapter_if #(.ADDR_W(16), .DATA_W(16)) mBus ();

    nios2_ram_width_adapter #(.RAM_DEPTH(51200)) dut (
        .clk   (clk),
        .reset (reset),
        .s     (sBus),
        .m     (mBus)
    );

    // Halfword RAM with byte enables and a one-cycle read latency.
    bit   [15:0] ram [0:51199];
    logic [15:0] ramQ = '0;
    always @(posedge clk) begin
        if (mBus.clken && mBus.chipselect && mBus.address < 16'd51200) begin
            if (mBus.write) begin
                if (mBus.byteenable[0]) ram[mBus.address][7:0]  <= mBus.writedata[7:0];
                if (mBus.byteenable[1]) ram[mBus.address][15:8] <= mBus.writedata[15:8];
            end
            ramQ <= ram[mBus.address];
        end
    end

    assign mBus.readdata      = ramQ;
    assign mBus.read          = 1'b0;
    assign mBus.waitrequest   = 1'b0;
    assign mBus.readdatavalid = 1'b0;
    assign sBus.chipselect    = 1'b0;
    assign sBus.clken         = 1'b0;

    int          ramCycles = 0;
    int          validCnt  = 0;
    logic [31:0] lastRd    = '0;
    always @(negedge clk) begin
        if (mBus.chipselect) ramCycles++;
        if (sBus.readdatavalid) begin
            validCnt++;
            lastRd = sBus.readdata;
        end
    end

    int errors = 0;
    int checks = 0;
    bit [31:0] refMem [0:25599];

    typedef struct {
        bit          wr;
        bit          rd;
        logic [14:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          cyc;
        bit          vld;
        logic [31:0] rdExp;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(bit wr, bit rd, logic [14:0] a, logic [3:0] be,
                                logic [31:0] wd, int cyc, bit vld, logic [31:0] rdExp);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.be = be; v.wd = wd;
        v.cyc = cyc; v.vld = vld; v.rdExp = rdExp;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit wr, input bit rd, input logic [14:0] a,
                                 input logic [3:0] be, input logic [31:0] wd);
        sBus.write      = wr;
        sBus.read       = rd;
        sBus.address    = a;
        sBus.byteenable = be;
        sBus.writedata  = wd;
    endtask

    // Presents a command from just after a rising edge, holds it until it is
    // accepted, and returns #1 after the accepting edge.
    task automatic issue(input bit wr, input bit rd, input logic [14:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        int n = 0;
        applyStimulus(wr, rd, a, be, wd);
        @(negedge clk);
        while (sBus.waitrequest && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) checkOutput("acceptTimeout", 32'd1, 32'd0);
        if (wr && a < 15'd25600)
            for (int b = 0; b < 4; b++)
                if (be[b]) refMem[a][8*b +: 8] = wd[8*b +: 8];
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, a, be, wd);
    endtask

    task automatic runCmd(input string name, input bit wr, input bit rd, input logic [14:0] a,
                          input logic [3:0] be, input logic [31:0] wd,
                          input int cyc, input bit vld, input logic [31:0] rdExp);
        int c0 = ramCycles;
        int v0 = validCnt;
        int n  = 0;
        issue(wr, rd, a, be, wd);
        @(negedge clk);
        while (sBus.waitrequest && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) checkOutput({name, "_idleTimeout"}, 32'd1, 32'd0);
        @(posedge clk);
        #1;
        checkOutput({name, "_ramCycles"}, 32'(ramCycles - c0), 32'(cyc));
        checkOutput({name, "_validPulses"}, 32'(validCnt - v0), 32'(vld));
        if (vld) checkOutput({name, "_readdata"}, lastRd, rdExp);
    endtask

    initial begin
        int v0;
        int c0;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstWaitreq", 32'(sBus.waitrequest), 32'd1);
        checkOutput("rstClken", 32'(mBus.clken), 32'd0);
        checkOutput("rstValid", 32'(sBus.readdatavalid), 32'd0);
        checkOutput("rstReaddata", sBus.readdata, 32'd0);
        checkOutput("rstMAddr", 32'(mBus.address), 32'd0);
        checkOutput("rstMBe", 32'(mBus.byteenable), 32'd0);
        checkOutput("rstMWd", 32'(mBus.writedata), 32'd0);
        checkOutput("rstMCsWr", 32'({mBus.chipselect, mBus.write}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("postRstWaitreq", 32'(sBus.waitrequest), 32'd0);
        checkOutput("postRstClken", 32'(mBus.clken), 32'd1);
        @(posedge clk);
        #1;

        // Full write, cycle by cycle.
        issue(1'b1, 1'b0, 15'h0123, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("wrT1Addr", 32'(mBus.address), 32'h0246);
        checkOutput("wrT1Be", 32'(mBus.byteenable), 32'd3);
        checkOutput("wrT1Data", 32'(mBus.writedata), 32'hBEEF);
        checkOutput("wrT1CsWr", 32'({mBus.chipselect, mBus.write}), 32'd3);
        checkOutput("wrT1Waitreq", 32'(sBus.waitrequest), 32'd1);
        @(negedge clk);
        checkOutput("wrT2Addr", 32'(mBus.address), 32'h0247);
        checkOutput("wrT2Data", 32'(mBus.writedata), 32'hDEAD);
        checkOutput("wrT2CsWr", 32'({mBus.chipselect, mBus.write}), 32'd3);
        @(negedge clk);
        checkOutput("wrT3Waitreq", 32'(sBus.waitrequest), 32'd0);
        checkOutput("wrT3Cs", 32'(mBus.chipselect), 32'd0);
        checkOutput("wrT3AddrHold", 32'(mBus.address), 32'h0247);
        @(posedge clk);
        #1;

        // Read back, cycle by cycle.
        issue(1'b0, 1'b1, 15'h0123, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("rdT1Addr", 32'(mBus.address), 32'h0246);
        checkOutput("rdT1CsWr", 32'({mBus.chipselect, mBus.write}), 32'd2);
        checkOutput("rdT1Be", 32'(mBus.byteenable), 32'd3);
        @(negedge clk);
        checkOutput("rdT2Addr", 32'(mBus.address), 32'h0247);
        checkOutput("rdT2CsWr", 32'({mBus.chipselect, mBus.write}), 32'd2);
        @(negedge clk);
        checkOutput("rdT3Cs", 32'(mBus.chipselect), 32'd0);
        checkOutput("rdT3Valid", 32'(sBus.readdatavalid), 32'd0);
        checkOutput("rdT3Waitreq", 32'(sBus.waitrequest), 32'd1);
        @(negedge clk);
        checkOutput("rdT4Valid", 32'(sBus.readdatavalid), 32'd1);
        checkOutput("rdT4Data", sBus.readdata, 32'hDEADBEEF);
        checkOutput("rdT4Waitreq", 32'(sBus.waitrequest), 32'd0);
        @(negedge clk);
        checkOutput("rdT5Valid", 32'(sBus.readdatavalid), 32'd0);
        @(posedge clk);
        #1;

        // Out-of-range read answers on the very next cycle with zero.
        c0 = ramCycles;
        issue(1'b0, 1'b1, 15'h6400, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("oorRdValid", 32'(sBus.readdatavalid), 32'd1);
        checkOutput("oorRdData", sBus.readdata, 32'd0);
        checkOutput("oorRdWaitreq", 32'(sBus.waitrequest), 32'd0);
        @(posedge clk);
        #1;

        // Out-of-range writes stream back-to-back with no RAM activity.
        applyStimulus(1'b1, 1'b0, 15'h7FFF, 4'hF, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("oorWrWaitreq%0d", i), 32'(sBus.waitrequest), 32'd0);
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checkOutput("oorRamCycles", 32'(ramCycles - c0), 32'd0);
        @(posedge clk);
        #1;

        vecs[0]  = mk(1, 0, 15'h0123, 4'hF, 32'hDEADBEEF, 2, 0, 32'h0);
        vecs[1]  = mk(0, 1, 15'h0123, 4'h0, 32'h0,        2, 1, 32'hDEADBEEF);
        vecs[2]  = mk(1, 0, 15'h0010, 4'hF, 32'hAAAA5555, 2, 0, 32'h0);
        vecs[3]  = mk(1, 0, 15'h0010, 4'hC, 32'h11223344, 1, 0, 32'h0);
        vecs[4]  = mk(0, 1, 15'h0010, 4'h0, 32'h0,        2, 1, 32'h11225555);
        vecs[5]  = mk(1, 0, 15'h0010, 4'h0, 32'hFFFFFFFF, 0, 0, 32'h0);
        vecs[6]  = mk(0, 1, 15'h0010, 4'h0, 32'h0,        2, 1, 32'h11225555);
        vecs[7]  = mk(1, 0, 15'h0010, 4'h1, 32'h000000CC, 1, 0, 32'h0);
        vecs[8]  = mk(0, 1, 15'h0010, 4'h0, 32'h0,        2, 1, 32'h112255CC);
        vecs[9]  = mk(0, 1, 15'h6400, 4'h0, 32'h0,        0, 1, 32'h0);
        vecs[10] = mk(1, 0, 15'h7FFF, 4'hF, 32'h12345678, 0, 0, 32'h0);
        vecs[11] = mk(0, 1, 15'h63FF, 4'h0, 32'h0,        2, 1, 32'h0);
        vecs[12] = mk(1, 0, 15'h63FF, 4'hF, 32'hCAFEF00D, 2, 0, 32'h0);
        vecs[13] = mk(0, 1, 15'h63FF, 4'h0, 32'h0,        2, 1, 32'hCAFEF00D);
        vecs[14] = mk(1, 1, 15'h0020, 4'hF, 32'h01020304, 2, 0, 32'h0);
        vecs[15] = mk(0, 1, 15'h0020, 4'h0, 32'h0,        2, 1, 32'h01020304);
        vecs[16] = mk(1, 0, 15'h0020, 4'h6, 32'hAABBCCDD, 2, 0, 32'h0);
        vecs[17] = mk(0, 1, 15'h0020, 4'h0, 32'h0,        2, 1, 32'h01BBCC04);
        vecs[18] = mk(1, 0, 15'h0010, 4'h8, 32'hEE000000, 1, 0, 32'h0);
        vecs[19] = mk(0, 1, 15'h0010, 4'h0, 32'h0,        2, 1, 32'hEE2255CC);
        for (int i = 0; i < 20; i++)
            runCmd($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].be,
                   vecs[i].wd, vecs[i].cyc, vecs[i].vld, vecs[i].rdExp);

        // Reset lands in the HI cycle of a read: the read must vanish.
        v0 = validCnt;
        issue(1'b0, 1'b1, 15'h0123, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midRstWaitreq", 32'(sBus.waitrequest), 32'd1);
        checkOutput("midRstClken", 32'(mBus.clken), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("afterRstWaitreq", 32'(sBus.waitrequest), 32'd0);
        checkOutput("afterRstCs", 32'(mBus.chipselect), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("cancelledValid", 32'(validCnt - v0), 32'd0);
        @(posedge clk);
        #1;
        runCmd("readAfterRst", 1'b0, 1'b1, 15'h0123, 4'h0, 32'h0, 2, 1'b1, 32'hDEADBEEF);

        for (int i = 0; i < 150; i++) begin
            logic [14:0] a;
            logic [3:0]  be;
            logic [31:0] wd;
            int          kind;
            bit          wr, rd, inRange;
            int          cyc;
            case ($urandom_range(0, 7))
                0:       a = 15'($urandom_range(25600, 32767));
                1:       a = 15'($urandom_range(25590, 25599));
                default: a = 15'($urandom_range(0, 15));
            endcase
            be   = 4'($urandom_range(0, 15));
            wd   = $urandom;
            kind = $urandom_range(0, 4);
            wr   = (kind == 1 || kind == 2 || kind == 3);
            rd   = (kind == 0 || kind == 3 || kind == 4);
            inRange = (a < 15'd25600);
            if (!inRange)  cyc = 0;
            else if (wr)   cyc = int'(be[1:0] != 2'b00) + int'(be[3:2] != 2'b00);
            else           cyc = 2;
            runCmd($sformatf("rnd%0d", i), wr, rd, a, be, wd, cyc, rd && !wr,
                   inRange ? refMem[a] : 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
